// File: rtl/win_pkg.sv
// win_pkg: shared FSM state encoding and frame/gap sizing functions for the windower blocks
package win_pkg;
  typedef enum logic [2:0] {IDLE, ARM, RUN, GAP, NEXT} state_t;
  function automatic int frame_beats(int log2_img, int ser);
    return 1 << (log2_img + $clog2(ser));
  endfunction
  function automatic int pad_len(int ser, int win);
    return ser * ((win - 1) / 2);
  endfunction
  function automatic int gap_len(int ser, int win);
    return pad_len(ser, win) + 2;
  endfunction
  function automatic int cnt_w(int log2_img, int ser);
    return log2_img + $clog2(ser) + 1;
  endfunction
endpackage

// File: rtl/windower_frame_sched_if.sv
// windower_frame_sched_if: FIFO head (src_count/src_data/src_pop) and windower input (win_vld_in/win_data_in); master = scheduler
interface windower_frame_sched_if #(parameter int NO_CH = 2, parameter int CNT_W = 11);
  logic [CNT_W-1:0] src_count;
  logic [NO_CH-1:0] src_data;
  logic src_pop;
  logic win_vld_in;
  logic [NO_CH-1:0] win_data_in;
  modport master(input src_count, src_data, output src_pop, win_vld_in, win_data_in);
  modport slave(output src_count, src_data, input src_pop, win_vld_in, win_data_in);
endinterface

// File: rtl/win_gap_timer.sv
// win_gap_timer: loadable down-counter (clk, rst active-low async, load, en) whose done flags the last enabled cycle
module win_gap_timer #(parameter int W = 3, parameter int LOAD = 3) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= load ? W'(LOAD) : (en && cnt != '0) ? cnt - 1'b1 : cnt;
  assign done = en && cnt == '0;
endmodule

// File: rtl/windower_frame_sched.sv
// windower_frame_sched: arms on a full frame in the FIFO, bursts it to the windower, holds the pad gap, counts frames; ports clk, rst (active-low async), cfg_*, bus (FIFO/windower), busy, frame_done, run_done, frame_idx, err_underflow
module windower_frame_sched
  import win_pkg::*;
#(
  parameter int NO_CH = 2,
  parameter int LOG2_IMG_SIZE = 10,
  parameter int WINDOW_SIZE = 3,
  parameter int SER_CYC = 1,
  parameter int LOG2_MAX_FRAMES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic cfg_start,
  input  logic [LOG2_MAX_FRAMES-1:0] cfg_num_frames,
  input  logic cfg_abort,
  windower_frame_sched_if.master bus,
  output logic busy,
  output logic frame_done,
  output logic run_done,
  output logic [LOG2_MAX_FRAMES-1:0] frame_idx,
  output logic err_underflow
);
  localparam int BEAT_W = LOG2_IMG_SIZE + $clog2(SER_CYC);
  localparam int CNT_W = cnt_w(LOG2_IMG_SIZE, SER_CYC);
  localparam int GAP_LEN = gap_len(SER_CYC, WINDOW_SIZE);
  localparam int GAP_W = $clog2(GAP_LEN + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(frame_beats(LOG2_IMG_SIZE, SER_CYC));
  localparam logic [BEAT_W-1:0] LAST = '1;
  state_t state, state_n;
  logic [BEAT_W-1:0] beat_cnt;
  logic [LOG2_MAX_FRAMES-1:0] num_q, idx_inc;
  logic abort_q, full_q, gap_done, empty, pop, accept, frame_end;
  assign empty = bus.src_count == '0;
  assign accept = state == IDLE && cfg_start && !cfg_abort;
  assign idx_inc = frame_idx + 1'b1;
  // only a frame whose last beat was popped counts; aborted or starved frames are dropped
  assign frame_end = state == GAP && gap_done && full_q;
  win_gap_timer #(.W(GAP_W), .LOAD(GAP_LEN - 1)) u_gap (
    .clk(clk),
    .rst(rst),
    .load(state_n == GAP && state != GAP),
    .en(state == GAP),
    .done(gap_done)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = accept ? ARM : IDLE;
      ARM:  state_n = cfg_abort ? IDLE : bus.src_count >= FULL ? RUN : ARM;
      RUN:  state_n = (cfg_abort || empty || beat_cnt == LAST) ? GAP : RUN;
      GAP:  state_n = gap_done ? NEXT : GAP;
      NEXT: state_n = (abort_q || cfg_abort || !full_q || (num_q != '0 && frame_idx == num_q)) ? IDLE : ARM;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    pop = state == RUN && !empty && !cfg_abort;
    bus.src_pop = pop;
    bus.win_vld_in = pop;
    bus.win_data_in = state == RUN ? bus.src_data : {NO_CH{1'b0}};
    busy = state != IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      beat_cnt <= '0;
      num_q <= '0;
      frame_idx <= '0;
      err_underflow <= 1'b0;
      abort_q <= 1'b0;
      full_q <= 1'b0;
      frame_done <= 1'b0;
      run_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      run_done <= frame_end && !abort_q && !cfg_abort && num_q != '0 && idx_inc == num_q;
      beat_cnt <= state == ARM ? '0 : beat_cnt + BEAT_W'(pop);
      full_q <= state == ARM ? 1'b0 : full_q | (pop && beat_cnt == LAST);
      abort_q <= state_n == IDLE ? 1'b0 : abort_q | (cfg_abort && (state == RUN || state == GAP || state == NEXT));
      num_q <= accept ? cfg_num_frames : num_q;
      frame_idx <= accept ? '0 : frame_end ? idx_inc : frame_idx;
      err_underflow <= accept ? 1'b0 : err_underflow | (state == RUN && empty && !cfg_abort);
    end
endmodule
